// File: rtl/uart_tx_if.sv
// uart_tx_if: byte valid/ready handshake into the UART transmitter.
interface uart_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    modport master(output tx_data, tx_valid, input tx_ready);
    modport slave(input tx_data, tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_unit.sv
// uart_tx_unit: LSB-first UART transmitter, 8N1/8N2, or 8E1/8E2 when UART_TX_PARITY_EN is defined.
module uart_tx_unit #(
    parameter int CLK_DIV   = 16,
    parameter int STOP_BITS = 1
) (
    input  logic clk,
    input  logic rst,
    uart_tx_if.slave s_if,
    output logic tx,
    output logic busy
);
    localparam int DW = $clog2(CLK_DIV);
`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif
    state_t r_state, w_state;
    logic [DW-1:0] r_div, w_div;
    logic [2:0]    r_bit, w_bit;
    logic [7:0]    r_shift, w_shift;
    logic          r_tx, w_tx;
    logic          w_tick;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_div   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state;
            r_div   <= w_div;
            r_bit   <= w_bit;
            r_shift <= w_shift;
            r_tx    <= w_tx;
        end
    end
    // r_bit counts data bits in DATA and stop bits in STOP; it is always 0 on entry to each.
    always_comb begin
        w_tick  = r_div == DW'(CLK_DIV - 1);
        w_state = r_state;
        w_div   = (r_state == IDLE || w_tick) ? '0 : r_div + DW'(1);
        w_bit   = r_bit;
        w_shift = r_shift;
        w_tx    = r_tx;
        case (r_state)
            IDLE: if (s_if.tx_valid) begin
                w_state = START;
                w_shift = s_if.tx_data;
                w_tx    = 1'b0;
            end
            START: if (w_tick) begin
                w_state = DATA;
                w_tx    = r_shift[0];
            end
            DATA: if (w_tick) begin
                w_bit = r_bit + 3'd1;
                if (r_bit == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                    w_state = PARITY;
                    w_tx    = ^r_shift;
`else
                    w_state = STOP;
                    w_tx    = 1'b1;
`endif
                end else begin
                    w_tx = r_shift[r_bit + 3'd1];
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (w_tick) begin
                w_state = STOP;
                w_tx    = 1'b1;
            end
`endif
            STOP: if (w_tick) begin
                w_state = (r_bit == 3'(STOP_BITS - 1)) ? IDLE : STOP;
                w_bit   = (r_bit == 3'(STOP_BITS - 1)) ? 3'd0 : r_bit + 3'd1;
            end
            default: w_state = IDLE;
        endcase
    end
    assign s_if.tx_ready = r_state == IDLE;
    assign busy          = r_state != IDLE;
    assign tx            = r_tx;
endmodule

// File: tb/tb_uart_tx_unit.sv
// tb_uart_tx_unit: randomized scoreboard bench for uart_tx_unit; honours UART_TX_PARITY_EN.
module tb_uart_tx_unit;
    localparam int CD = 4;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1, SB = 2;
`else
    localparam int P = 0, SB = 1;
`endif
    localparam int N = 1 + 8 + P + SB;
    typedef struct {
        logic [7:0] b;
        int         k;
    } exp_t;
    logic clk = 1'b0, rst = 1'b0, tx, busy;
    int cyc = 0, vectors = 0, miscompares = 0, last_end = 0;
    bit mon_en = 1'b0;
    exp_t sb[$];
    uart_tx_if u_if();
    uart_tx_unit #(.CLK_DIV(CD), .STOP_BITS(SB)) dut (.clk(clk), .rst(rst), .s_if(u_if), .tx(tx), .busy(busy));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask
    // Start cycle comes from the frame-length model, never from observing tx_ready.
    task automatic send(input logic [7:0] b, input bit noise);
        int k;
        exp_t e;
        k = (cyc + 1 > last_end + 1) ? cyc + 1 : last_end + 1;
        while (cyc < k - 1) begin
            if (cyc < last_end) begin
                u_if.tx_valid = noise ? 1'($urandom_range(0, 1)) : 1'b1;
                u_if.tx_data  = noise ? 8'($urandom) : b;
            end else begin
                u_if.tx_valid = 1'b0;
            end
            @(negedge clk);
        end
        u_if.tx_valid = 1'b1;
        u_if.tx_data  = b;
        e.b = b;
        e.k = k;
        sb.push_back(e);
        last_end = k + N * CD;
        @(negedge clk);
        u_if.tx_valid = 1'b0;
    endtask
    initial begin
        exp_t e;
        logic [11:0] fb;
        bit bad;
        forever begin
            @(negedge clk);
            if (mon_en && !rst && tx === 1'b0) begin
                if (sb.size() == 0) begin
                    chk("spurious_start", 1, 0);
                end else begin
                    e  = sb.pop_front();
                    fb = '1;
                    fb[0] = 1'b0;
                    fb[8:1] = e.b;
                    if (P == 1) fb[9] = ^e.b;
                    chk("start_cycle", cyc, e.k);
                    for (int i = 0; i < N; i++) begin
                        bad = 1'b0;
                        for (int j = 0; j < CD; j++) begin
                            if (i != 0 || j != 0) @(negedge clk);
                            if (tx !== fb[i] || busy !== 1'b1 || u_if.tx_ready !== 1'b0) bad = 1'b1;
                        end
                        chk($sformatf("frame_%02h_bit%0d", e.b, i), {31'd0, bad}, 0);
                    end
                    @(negedge clk);
                    chk("idle_after_frame", {29'd0, tx, busy, u_if.tx_ready}, 32'b101);
                end
            end
        end
    end
    initial begin
        bit stray;
        u_if.tx_valid = 1'b0;
        u_if.tx_data  = 8'h00;
        #3 rst = 1'b1;
        #1 chk("reset_async", {29'd0, tx, busy, u_if.tx_ready}, 32'b101);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_no_valid", {29'd0, tx, busy, u_if.tx_ready}, 32'b101);
        mon_en   = 1'b1;
        last_end = cyc;
        send(8'h55, 1'b0);
        repeat (50) @(negedge clk);
        send(8'hA5, 1'b0);
        send(8'h3C, 1'b0);
        send(8'h0F, 1'b0);
        send(8'hFF, 1'b0);
        send(8'h07, 1'b0);
        send(8'h03, 1'b0);
        send(8'h00, 1'b1);
        send(8'h80, 1'b1);
        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 60)) @(negedge clk);
            send(8'($urandom), 1'($urandom_range(0, 1)));
        end
        for (int t = 0; t < 5000 && (sb.size() != 0 || cyc <= last_end + 1); t++) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        mon_en = 1'b0;
        u_if.tx_valid = 1'b1;
        u_if.tx_data  = 8'hC3;
        @(negedge clk);
        u_if.tx_valid = 1'b0;
        repeat (4 * CD + 1) @(negedge clk);
        chk("c3_data_bit3", {31'd0, tx}, 0);
        #2 rst = 1'b1;
        #1 chk("reset_mid_frame", {29'd0, tx, busy, u_if.tx_ready}, 32'b101);
        @(negedge clk);
        rst = 1'b0;
        stray = 1'b0;
        repeat (2 * N * CD) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) stray = 1'b1;
        end
        chk("quiet_after_abort", {31'd0, stray}, 0);
        mon_en   = 1'b1;
        last_end = cyc;
        send(8'h5A, 1'b1);
        for (int t = 0; t < 500 && (sb.size() != 0 || cyc <= last_end + 1); t++) @(negedge clk);
        chk("recovery_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/uart_tx_unit.md
Name: uart_tx_unit

Overview:
Serial UART transmitter, 8N1 by default: the transmit end of the board UART link, driving the top-level uart_tx pin.
- Accepts bytes over a valid/ready handshake, e.g. ALU result/flags or debug bytes from on-board logic.
- Shifts each byte out LSB-first at a fixed clocks-per-bit rate.
- The single-clock, non-FIFO companion to the board's serial receive path.

Parameters:
CLK_DIV, 16, clock cycles per serial bit; legal range 2..65535.
STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
tx_data  input  8  byte to send, sampled on handshake
tx_valid  input  1  producer has a byte on tx_data
tx_ready  output  1  block can accept a byte this cycle
tx  output  1  serial line, idle high, registered
busy  output  1  high while a frame is on the line

Behaviour:
Reset:
- rst asserted (asynchronous): state=IDLE, tx=1, tx_ready=1, busy=0, bit counter=0, divider=0.
- Reset mid-frame aborts the frame immediately: tx returns high with no partial stop bit, and the aborted byte is lost.

States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.

Handshake and outputs:
- tx_ready = (state==IDLE), combinational from state.
- Transfer occurs on a rising edge with tx_valid=1 and tx_ready=1.
- At that edge: tx_data is latched into the shift register, state goes to START, busy goes to 1, tx goes to 0.
- Latency: the start bit appears on tx in the first cycle after the handshake edge.
- tx_valid or tx_data changes while not ready are ignored; the latched byte is never affected.
- tx_valid=0 in IDLE: tx stays 1, nothing happens.

Bit timing:
- Every bit (start, data, parity, each stop bit) holds tx for exactly CLK_DIV cycles.
- Divider counts 0..CLK_DIV-1; the bit advances when divider==CLK_DIV-1, and the divider wraps to 0.
- DATA: bit 0 is sent first; after 8 data bits, go to PARITY (when enabled) else STOP.
- STOP: tx=1 for STOP_BITS*CLK_DIV cycles, then IDLE. busy stays 1 through the final stop cycle and drops with the return to IDLE.

Frame period:
- One frame occupies (1+8+P+STOP_BITS)*CLK_DIV cycles, where P=1 with parity and 0 without.
- With tx_valid held high, the next handshake happens in the first IDLE cycle.
- Back-to-back frames are therefore separated by exactly 1 idle-high cycle beyond the stop bits.

Widths:
- Divider width = $clog2(CLK_DIV).
- Bit counter is 3 bits and wraps 7->0 on exit from DATA.

Optional Feature:
UART_TX_PARITY_EN
- Defined: a PARITY state is inserted between DATA and STOP. It drives the even-parity bit (XOR of the 8 latched data bits) for CLK_DIV cycles. The frame becomes 8E1/8E2.
- Undefined: no parity state or logic, and the frame is 8N1/8N2.

Test Plan:
1. Reset: rst=1 pulsed asynchronously between clock edges -> tx=1, tx_ready=1, busy=0 immediately, with no clock edge required.
2. Single byte: CLK_DIV=4, STOP_BITS=1, send 0x55 -> starting the cycle after the handshake, tx shows 0 for 4 cycles, then 1,0,1,0,1,0,1,0 each for 4 cycles, then 1 for 4 cycles. busy=1 for exactly 40 cycles; tx_ready low for the same 40 cycles.
3. Back-to-back: tx_valid held high with 0xA5 then 0x3C, CLK_DIV=4 -> second start bit begins 41 cycles after the first. Bit sequences are LSB-first 1,0,1,0,0,1,0,1 and then 0,0,1,1,1,1,0,0.
4. Ignore while busy: mid-frame of 0x0F, drive tx_data=0xFF with tx_valid=1 -> the wire still carries 0x0F. 0xFF is accepted only at the next IDLE edge if tx_valid is still high.
5. Reset mid-frame: assert rst during data bit 3 of 0xC3 -> tx=1 at once. After release with tx_valid=0, tx stays 1 and no stray stop/start bits appear.
6. Parity (UART_TX_PARITY_EN defined, CLK_DIV=4, STOP_BITS=2): send 0x07 -> parity bit 1, send 0x03 -> parity bit 0. Each frame lasts 48 cycles, ending with 8 high stop cycles.
